tqvp_htfab_pdm_rx: RTL and testbench

//  TinyQV peripheral that receives a 1-bit PDM/delta-sigma stream, the decoding end of our duty/bitstream outputs.
//  It drives a PDM clock pin, samples one selected ui_in pin on each PDM clock, and sinc2-decimates by R.

---
 rtl/tqvp_pdm_rx_pkg.sv | 34 +++
 rtl/tqvp_htfab_pdm_rx_decim.sv | 91 +++++++++
 rtl/tqvp_htfab_pdm_rx.sv | 143 ++++++++++++++
 tb/tb_tqvp_htfab_pdm_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_pdm_rx_pkg.sv
`default_nettype none
// =============================================================================
// tqvp_pdm_rx_pkg - register map, CTRL layout and shared helpers for the PDM RX
// Rev 1.0
// =============================================================================
package tqvp_pdm_rx_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int ACC_W      = 9;

    localparam logic [3:0] ADDR_CTRL = 4'd0;
    localparam logic [3:0] ADDR_DIV  = 4'd1;
    localparam logic [3:0] ADDR_DATA = 4'd2;
    localparam logic [3:0] ADDR_STAT = 4'd3;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_CHAN_LSB    = 1;
    localparam int CTRL_KC_LSB      = 4;
    localparam int CTRL_FLUSH_BIT   = 6;
    localparam int STAT_OVF_CLR_BIT = 3;

    typedef struct packed {
        logic [1:0] kc;
        logic [2:0] chan;
        logic       en;
    } ctrl_t;

    // Index of the last sample in a decimation frame: R-1 with R = 2^(kc+1).
    function automatic logic [3:0] dec_last(input logic [1:0] kc);
        return 4'((5'd2 << kc) - 5'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tqvp_htfab_pdm_rx_decim.sv
`default_nettype none
// =============================================================================
// pdm_sinc2_decim - sinc2 integrate/decimate/comb filter with settle and normalise
// Rev 1.0
// =============================================================================
module pdm_sinc2_decim #(
    parameter int ACC_W = tqvp_pdm_rx_pkg::ACC_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       smp_en,
    input  logic       x,
    input  logic [1:0] kc,
    output logic       out_valid,
    output logic [7:0] out
);
    import tqvp_pdm_rx_pkg::*;

    logic [ACC_W-1:0] i1_q, i2_q, i2_prev_q, c1_prev_q;
    logic [3:0]       dec_cnt_q;
    logic [1:0]       settle_q;
    logic             out_valid_q;
    logic [7:0]       out_q;

    logic [ACC_W-1:0] i1_d, i2_d, c1_d, y_d;
    logic             last_d;
    logic [7:0]       norm_d;

    // Scale y so that a full-scale R^2 lands at 256, then saturate to 8 bits.
    function automatic logic [7:0] normalise(input logic [ACC_W-1:0] y, input logic [1:0] k);
        logic [ACC_W+5:0] s;
        s = {6'd0, y} << (3'd6 - {k, 1'b0});
        return (|s[ACC_W+5:8]) ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        i1_d   = i1_q + ACC_W'(x);
        i2_d   = i2_q + i1_d;
        c1_d   = i2_d - i2_prev_q;
        y_d    = c1_d - c1_prev_q;
        last_d = (dec_cnt_q == dec_last(kc));
        norm_d = normalise(y_d, kc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i2_prev_q   <= '0;
            c1_prev_q   <= '0;
            dec_cnt_q   <= '0;
            settle_q    <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (restart) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i2_prev_q   <= '0;
            c1_prev_q   <= '0;
            dec_cnt_q   <= '0;
            settle_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (smp_en) begin
                i1_q <= i1_d;
                i2_q <= i2_d;
                if (last_d) begin
                    dec_cnt_q <= '0;
                    i2_prev_q <= i2_d;
                    c1_prev_q <= c1_d;
                    // The comb history is not meaningful until two frames have passed.
                    if (settle_q == 2'd2) begin
                        out_valid_q <= 1'b1;
                        out_q       <= norm_d;
                    end else begin
                        settle_q <= settle_q + 2'd1;
                    end
                end else begin
                    dec_cnt_q <= dec_cnt_q + 4'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule
`default_nettype wire

// File: rtl/tqvp_htfab_pdm_rx.sv
`default_nettype none
// =============================================================================
// tqvp_htfab_pdm_rx - TinyQV PDM receiver: clock generator, sinc2 decimator, sample FIFO
// Rev 1.0
// =============================================================================
module tqvp_htfab_pdm_rx #(
    parameter int FIFO_DEPTH = tqvp_pdm_rx_pkg::FIFO_DEPTH,
    parameter int ACC_W      = tqvp_pdm_rx_pkg::ACC_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    import tqvp_pdm_rx_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    ctrl_t          ctrl_q;
    logic [7:0]     div_q, div_act_q, div_cnt_q;
    logic           pdm_clk_q;
    logic [7:0]     fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic           ovf_q;

    logic           wr_ctrl_d, wr_div_d, wr_data_d, wr_stat_d;
    logic           restart_d, reload_d, smp_en_d;
    logic           fifo_full_d, fifo_empty_d, pop_d, push_d, flush_d, ovf_set_d;
    logic           dec_valid_d;
    logic [7:0]     dec_out_d;
    logic           unused_bits;

    always_comb begin
        wr_ctrl_d    = data_write && (address == ADDR_CTRL);
        wr_div_d     = data_write && (address == ADDR_DIV);
        wr_data_d    = data_write && (address == ADDR_DATA);
        wr_stat_d    = data_write && (address == ADDR_STAT);
        restart_d    = wr_ctrl_d || !ctrl_q.en;
        reload_d     = (div_cnt_q == div_act_q);
        smp_en_d     = !restart_d && reload_d && pdm_clk_q;
        fifo_full_d  = (count_q == CW'(FIFO_DEPTH));
        fifo_empty_d = (count_q == '0);
        flush_d      = wr_ctrl_d && data_in[CTRL_FLUSH_BIT];
        pop_d        = wr_data_d && !fifo_empty_d;
        // A pop in the same cycle frees the slot the incoming sample needs.
        push_d       = dec_valid_d && !flush_d && (!fifo_full_d || pop_d);
        ovf_set_d    = dec_valid_d && !flush_d && fifo_full_d && !pop_d;
    end

    pdm_sinc2_decim #(
        .ACC_W(ACC_W)
    ) u_decim (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart_d),
        .smp_en   (smp_en_d),
        .x        (ui_in[ctrl_q.chan]),
        .kc       (ctrl_q.kc),
        .out_valid(dec_valid_d),
        .out      (dec_out_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            div_q     <= '0;
            div_act_q <= '0;
            div_cnt_q <= '0;
            pdm_clk_q <= 1'b0;
        end else begin
            if (wr_ctrl_d) begin
                ctrl_q.en   <= data_in[CTRL_EN_BIT];
                ctrl_q.chan <= data_in[CTRL_CHAN_LSB +: 3];
                ctrl_q.kc   <= data_in[CTRL_KC_LSB +: 2];
            end
            if (wr_div_d) begin
                div_q <= data_in;
            end
            // A new DIV value is only picked up when the half-period counter reloads.
            if (restart_d) begin
                div_cnt_q <= '0;
                pdm_clk_q <= 1'b0;
                div_act_q <= div_q;
            end else if (reload_d) begin
                div_cnt_q <= '0;
                pdm_clk_q <= ~pdm_clk_q;
                div_act_q <= div_q;
            end else begin
                div_cnt_q <= div_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (flush_d) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_d) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_d)  rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push_d && !pop_d)      count_q <= count_q + CW'(1);
                else if (!push_d && pop_d) count_q <= count_q - CW'(1);
            end
            if (ovf_set_d)
                ovf_q <= 1'b1;
            else if (wr_stat_d && data_in[STAT_OVF_CLR_BIT])
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_d) fifo_mem_q[wr_ptr_q] <= dec_out_d;
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL: data_out = {2'b00, ctrl_q.kc, ctrl_q.chan, ctrl_q.en};
            ADDR_DIV:  data_out = div_q;
            ADDR_DATA: data_out = fifo_empty_d ? 8'h00 : fifo_mem_q[rd_ptr_q];
            ADDR_STAT: data_out = {3'b000, fifo_empty_d, ovf_q, 3'(count_q)};
            default:   data_out = 8'h00;
        endcase
    end

    assign uo_out      = {5'b00000, !fifo_empty_d, pdm_clk_q, 1'b0};
    assign unused_bits = data_in[7];

endmodule
`default_nettype wire

// File: tb/tb_tqvp_htfab_pdm_rx.sv
`default_nettype none
// =============================================================================
// tb_tqvp_htfab_pdm_rx - scoreboard bench for the PDM receiver peripheral
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_tqvp_htfab_pdm_rx;

    localparam logic [3:0] A_CTRL = 4'd0;
    localparam logic [3:0] A_DIV  = 4'd1;
    localparam logic [3:0] A_DATA = 4'd2;
    localparam logic [3:0] A_STAT = 4'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'd0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    tqvp_htfab_pdm_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ui_in     (ui_in),
        .uo_out    (uo_out),
        .address   (address),
        .data_write(data_write),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] want;
        string      nm;
    } exp_t;

    exp_t       sb_q[$];
    logic       req = 1'b0;
    int         sel = 0;
    logic [7:0] obs_val = 8'h00;
    bit         done = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] mon_got;
    exp_t       mon_e;

    // Monitor: whenever a request is presented, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (req) begin
            mon_got = (sel == 0) ? data_out : (sel == 1) ? uo_out : obs_val;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: got %02h, nothing expected", mon_got);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_got !== mon_e.want) begin
                    bad++;
                    $display("FAIL %s: got %02h want %02h", mon_e.nm, mon_got, mon_e.want);
                end
            end
        end else if (done) begin
            if (sb_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_leftover: got %0d pending want 0", sb_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic issue(input int s, input logic [7:0] v, input logic [7:0] want, input string nm);
        exp_t e;
        @(posedge clk); #1;
        e.want = want;
        e.nm   = nm;
        sb_q.push_back(e);
        sel     = s;
        obs_val = v;
        req     = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] want, input string nm);
        address = a;
        issue(0, 8'h00, want, nm);
    endtask

    task automatic check(input logic [7:0] act, input logic [7:0] want, input string nm);
        issue(2, act, want, nm);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(posedge clk); #1;
        data_write = 1'b0;
    endtask

    task automatic wait_pdm_rise(output int cyc);
        logic p;
        p   = uo_out[1];
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (!p && uo_out[1]) begin
                cyc = i;
                return;
            end
            p = uo_out[1];
        end
    endtask

    // Counts pdm_clk falling edges (sample points) until the FIFO reports non-empty.
    task automatic falls_to_push(output int falls);
        int   f;
        logic p;
        f     = 0;
        p     = uo_out[1];
        falls = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (uo_out[2]) begin
                falls = f;
                return;
            end
            if (p && !uo_out[1]) f++;
            p = uo_out[1];
        end
    endtask

    int   c, falls, f;
    logic p;
    bit   hit, seen;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rd(A_STAT, 8'h10, "stat_after_reset");
        rd(A_DATA, 8'h00, "data_after_reset");
        rd(A_DIV,  8'h00, "div_after_reset");
        issue(1, 8'h00, 8'h00, "uo_after_reset");

        // All-ones at R=2: settle, first push timing, pdm period, overflow.
        ui_in = 8'h01;
        wr(A_DIV, 8'h01);
        wr(A_CTRL, 8'h01);
        falls_to_push(falls);
        wait_pdm_rise(c);
        wait_pdm_rise(c);
        check(8'(falls), 8'd6, "first_push_sample_count");
        check(8'(c), 8'd4, "pdm_period_div1");
        repeat (120) @(posedge clk);
        wr(A_CTRL, 8'h00);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | uo_out[1];
        end
        check({7'b0, seen}, 8'h00, "pdm_held_low_en0");
        rd(A_STAT, 8'h0C, "stat_full_ovf");
        rd(A_DATA, 8'hFF, "data_ones_r2");
        wr(A_STAT, 8'h08);
        rd(A_STAT, 8'h04, "stat_ovf_cleared");
        for (int k = 0; k < 4; k++) begin
            rd(A_DATA, 8'hFF, "data_ones_drain");
            wr(A_DATA, 8'h00);
        end
        rd(A_STAT, 8'h10, "stat_drained");
        wr(A_DATA, 8'h00);
        rd(A_STAT, 8'h10, "stat_pop_when_empty");

        // All-zeros at R=2.
        ui_in = 8'h00;
        wr(A_CTRL, 8'h01);
        falls_to_push(falls);
        wr(A_CTRL, 8'h00);
        check(8'(falls), 8'd6, "zeros_first_push_sample_count");
        rd(A_STAT, 8'h01, "stat_one_zero_sample");
        rd(A_DATA, 8'h00, "data_zeros_r2");
        wr(A_DATA, 8'h00);
        rd(A_STAT, 8'h10, "stat_after_zero_pop");

        // Alternating 1,0 at R=4: two settled outputs (samples 12 and 16) of y=8.
        ui_in = 8'h00;
        wr(A_CTRL, 8'h11);
        for (int k = 0; k < 18; k++) begin
            wait_pdm_rise(c);
            ui_in[0] = ~ui_in[0];
        end
        wr(A_CTRL, 8'h00);
        check(8'(c), 8'd4, "alt_rise_spacing");
        rd(A_STAT, 8'h02, "stat_alt_two");
        rd(A_DATA, 8'h80, "data_alt_r4");

        // Fill to four behind the two 0x80 entries, then pop exactly on the sample-10 push.
        ui_in = 8'h01;
        wr(A_CTRL, 8'h01);
        f   = 0;
        hit = 1'b0;
        p   = uo_out[1];
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (p && !uo_out[1]) begin
                f++;
                if (f == 9) hit = 1'b1;
            end
            p = uo_out[1];
        end
        if (hit) begin
            repeat (4) @(posedge clk);
            #1;
            address    = A_DATA;
            data_write = 1'b1;
            @(posedge clk); #1;
            data_write = 1'b0;
        end
        wr(A_CTRL, 8'h00);
        check({7'b0, hit}, 8'h01, "coincide_sync_found");
        rd(A_STAT, 8'h04, "stat_push_pop_full");
        rd(A_DATA, 8'h80, "data_order_head");
        wr(A_DATA, 8'h00);
        rd(A_DATA, 8'hFF, "data_order_next");
        rd(A_STAT, 8'h03, "stat_three_before_flush");

        // Flush with channel switch: data now comes from ui_in[6].
        ui_in = 8'h40;
        wr(A_CTRL, 8'h4D);
        rd(A_STAT, 8'h10, "stat_after_flush");
        rd(A_CTRL, 8'h0D, "ctrl_flush_selfclear");
        rd(A_DIV,  8'h01, "div_readback");
        rd(4'd5,   8'h00, "unmapped_reads_zero");
        falls_to_push(falls);
        wr(A_CTRL, 8'h0C);
        check({7'b0, falls >= 0}, 8'h01, "chan6_push_seen");
        rd(A_DATA, 8'hFF, "data_chan6");
        rd(A_STAT, 8'h01, "stat_chan6_one");

        // Reset in the middle of a running stream.
        ui_in = 8'h01;
        wr(A_CTRL, 8'h01);
        falls_to_push(falls);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        issue(1, 8'h00, 8'h00, "uo_after_midstream_reset");
        rd(A_STAT, 8'h10, "stat_after_midstream_reset");
        rd(A_DATA, 8'h00, "data_after_midstream_reset");
        rd(A_CTRL, 8'h00, "ctrl_after_midstream_reset");

        @(posedge clk); #1;
        done = 1'b1;
    end

endmodule
`default_nettype wire
